// File: rtl/game_fsm.sv
// game_fsm: top-level Frogger game sequencer.
// Drives the shared state encoding (MENU=0, PLAYING=1, DEAD=2, WIN=3) and
// tracks lives, the per-life countdown, the win count and the respawn pulse.
// Optional feature macro: GAME_TIMER_EN (per-life countdown with expiry death).
// Without it, time_left is held at TIME_LIMIT_S and only collisions kill.
module game_fsm #(
   parameter int START_LIVES  = 3,
   parameter int DEAD_FRAMES  = 90,
   parameter int TIME_LIMIT_S = 30,
   parameter int FRAMES_PER_S = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start_tick,
   input  logic       collision,
   input  logic       reached_end,
   output logic [1:0] state,
   output logic [1:0] lives,
   output logic [5:0] time_left,
   output logic [7:0] wins,
   output logic       respawn
);

   typedef enum logic [1:0] {
      MENU    = 2'd0,
      PLAYING = 2'd1,
      DEAD    = 2'd2,
      WIN     = 2'd3
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [5:0] TIME_INIT  = 6'(TIME_LIMIT_S);
   // The dead wait ends on the frame tick that brings the count to DEAD_FRAMES
   localparam logic [7:0] DEAD_LAST  = 8'(DEAD_FRAMES - 1);

   // Reject illegal parameter values at elaboration
   if (START_LIVES < 1 || START_LIVES > 3) begin : g_bad_start_lives
      $error("game_fsm: START_LIVES must be 1..3");
   end
   if (DEAD_FRAMES < 1 || DEAD_FRAMES > 255) begin : g_bad_dead_frames
      $error("game_fsm: DEAD_FRAMES must be 1..255");
   end
   if (TIME_LIMIT_S < 1 || TIME_LIMIT_S > 63) begin : g_bad_time_limit
      $error("game_fsm: TIME_LIMIT_S must be 1..63");
   end
   if (FRAMES_PER_S < 1 || FRAMES_PER_S > 127) begin : g_bad_frames_per_s
      $error("game_fsm: FRAMES_PER_S must be 1..127");
   end

   state_t     state_q;
   logic [1:0] lives_q;
   logic [5:0] time_left_q;
   logic [7:0] wins_q;
   logic       respawn_q;
   logic [7:0] dead_cnt_q;
   logic       timer_expire_d;

`ifdef GAME_TIMER_EN
   localparam logic [6:0] SUB_LAST = 7'(FRAMES_PER_S - 1);
   logic [6:0] sub_cnt_q;
   logic       sec_wrap_d;

   // A second elapses on the frame tick that completes FRAMES_PER_S ticks
   assign sec_wrap_d     = frame_tick && (sub_cnt_q == SUB_LAST);
   // Expiry is the 1 -> 0 step of the countdown
   assign timer_expire_d = sec_wrap_d && (time_left_q == 6'd1);
`else
   assign timer_expire_d = 1'b0;
`endif

   // Game sequencing, lives/wins bookkeeping and the per-life countdown
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= MENU;
         lives_q     <= '0;
         time_left_q <= '0;
         wins_q      <= '0;
         respawn_q   <= 1'b0;
         dead_cnt_q  <= '0;
`ifdef GAME_TIMER_EN
         sub_cnt_q   <= '0;
`endif
      end else begin
         respawn_q <= 1'b0;
`ifndef GAME_TIMER_EN
         time_left_q <= TIME_INIT;
`endif
         case (state_q)
            MENU: begin
               if (start_tick) begin
                  state_q   <= PLAYING;
                  lives_q   <= LIVES_INIT;
                  respawn_q <= 1'b1;
`ifdef GAME_TIMER_EN
                  time_left_q <= TIME_INIT;
                  sub_cnt_q   <= '0;
`endif
               end
            end
            PLAYING: begin
`ifdef GAME_TIMER_EN
               if (frame_tick) begin
                  if (sec_wrap_d) begin
                     sub_cnt_q   <= '0;
                     time_left_q <= time_left_q - 6'd1;
                  end else begin
                     sub_cnt_q <= sub_cnt_q + 7'd1;
                  end
               end
`endif
               // Collision and expiry in one cycle are a single death
               if (collision || timer_expire_d) begin
                  state_q    <= DEAD;
                  lives_q    <= lives_q - 2'd1;
                  dead_cnt_q <= '0;
               end else if (reached_end) begin
                  state_q <= WIN;
                  if (wins_q != 8'hFF) begin
                     wins_q <= wins_q + 8'd1;
                  end
               end
            end
            DEAD: begin
               if (lives_q == 2'd0) begin
                  // Game over: wait for the player to return to the menu
                  if (start_tick) begin
                     state_q <= MENU;
                  end
               end else if (frame_tick) begin
                  if (dead_cnt_q == DEAD_LAST) begin
                     state_q    <= PLAYING;
                     respawn_q  <= 1'b1;
                     dead_cnt_q <= '0;
`ifdef GAME_TIMER_EN
                     time_left_q <= TIME_INIT;
                     sub_cnt_q   <= '0;
`endif
                  end else begin
                     dead_cnt_q <= dead_cnt_q + 8'd1;
                  end
               end
            end
            WIN: begin
               if (start_tick) begin
                  state_q <= MENU;
               end
            end
            default: state_q <= MENU;
         endcase
      end
   end

   assign state     = state_q;
   assign lives     = lives_q;
   assign time_left = time_left_q;
   assign wins      = wins_q;
   assign respawn   = respawn_q;

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level game sequencer for the Frogger datapath. Owns the `state` encoding consumed by the frog movement block (MENU=0, PLAYING=1, DEAD=2, WIN=3) and sequences the game from the frog's `reached_end` and the collision detector's `collision`. It tracks lives, a per-life countdown timer and a win count, and emits a one-cycle `respawn` pulse whenever a fresh life starts.

## Interface
Parameters:
- `START_LIVES`, 3: lives loaded on game start; legal range 1..3.
- `DEAD_FRAMES`, 90: frame ticks spent in DEAD before an automatic respawn; legal range 1..255.
- `TIME_LIMIT_S`, 30: per-life countdown in seconds; legal range 1..63.
- `FRAMES_PER_S`, 60: frame ticks per timer second; legal range 1..127.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start_tick` in 1: debounced one-cycle start-button pulse.
- `collision` in 1: frog hit a hazard; level-sensitive, sampled every cycle.
- `reached_end` in 1: frog is in the goal row.
- `state` out 2: game state.
- `lives` out 2: lives remaining.
- `time_left` out 6: seconds remaining for the current life.
- `wins` out 8: completed crossings; saturates at 255.
- `respawn` out 1: one-cycle pulse that starts a new life.

## Operation
- All outputs are registered.
- Reset values: `state`=MENU, `lives`=0, `time_left`=0, `wins`=0, `respawn`=0. Reset also clears the internal frame and dead counters.
- MENU:
  - `start_tick` → PLAYING, with `lives`=START_LIVES, `time_left`=TIME_LIMIT_S, sub-second counter=0 and `respawn`=1 for that one cycle.
  - All other inputs are ignored.
- PLAYING, death event (`collision`, or timer expiry when the timer is enabled):
  - → DEAD and `lives` decrements by 1.
  - Simultaneous collision and timer expiry is a single death and a single decrement.
- PLAYING, `reached_end` with no death event in the same cycle → WIN and `wins` increments, saturating at 255. Collision takes priority over `reached_end`.
- PLAYING ignores `start_tick`.
- DEAD with `lives`≠0:
  - Dead counter clears on entry and increments on each `frame_tick`.
  - When it reaches DEAD_FRAMES → PLAYING, with `respawn`=1, `time_left`=TIME_LIMIT_S and sub-second counter=0.
  - `start_tick` is ignored.
- DEAD with `lives`=0 (game over):
  - Stays in DEAD, ignoring the dead counter.
  - `start_tick` → MENU.
- WIN: `start_tick` → MENU. `lives` and `time_left` hold their values.
- `collision` and `reached_end` are ignored outside PLAYING.
- `wins` is cleared only by reset.

## Timing
- An input event in cycle N produces the new `state`, `lives` and `wins` values in cycle N+1. `respawn` is high in N+1 only.
- Timer, only while PLAYING:
  - Each `frame_tick` increments the sub-second counter.
  - At FRAMES_PER_S ticks the counter wraps to 0 and `time_left` decrements in the same cycle.
  - A decrement from 1 to 0 is the timer-expiry death event: `time_left`=0 and `state`=DEAD appear together in the next cycle.
- `frame_tick` coincident with a state transition is consumed by the new state's counters starting the cycle after the transition.
- Asserting `reset_n` low at any time forces the reset values immediately, without waiting for a clock edge.
- Back-to-back `start_tick` pulses each cause at most one transition per cycle. Each pulse is evaluated against the current registered state.

## Configuration
- `GAME_TIMER_EN` defined: countdown timer logic is present and timer expiry is a death event, as described above.
- `GAME_TIMER_EN` undefined:
  - No sub-second counter or timer decrement is built.
  - `time_left` is tied to TIME_LIMIT_S while not in reset and to 0 during reset.
  - Only `collision` kills the frog.

## Test plan
- Reset, then `start_tick` → `state`=1, `lives`=3, `time_left`=30, one-cycle `respawn`.
- In PLAYING, assert `collision` one cycle → `state`=2, `lives`=2. After 90 `frame_tick` pulses → `state`=1, `respawn` pulse, `time_left`=30.
- Three collisions, each followed by the 90-frame wait → `lives`=0, `state` held at 2 for 200+ frames. Then `start_tick` → `state`=0.
- `collision` and `reached_end` asserted in the same cycle → `state`=2, `wins` unchanged. Then `reached_end` alone on a later life → `state`=3, `wins`=1. Drive 300 wins → `wins` stays at 255.
- With `GAME_TIMER_EN`, FRAMES_PER_S=2 and TIME_LIMIT_S=2: four frame ticks → `time_left` steps 2→1→0 and `state`=2 with `lives` decremented once. Same test without the macro → `time_left` stays 2 and `state` stays 1.
- Drop `reset_n` mid-DEAD countdown → all outputs take their reset values asynchronously, and the state is MENU after release.
